// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  // Default operand and sum width.
  localparam int unsigned SADD_N = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sadd_bitcnt.sv
// Bit counter for the serial adder: clear, enable, and a flag on the last bit.
module sadd_bitcnt
  import serial_adder_pkg::*;
#(
  parameter int unsigned N = SADD_N,
  parameter int unsigned W = clog2(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [W-1:0] LastVal = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, then modulo increment that returns to 0 after the last bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == LastVal);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell, LSB first, start/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned N = SADD_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         co
);

  localparam int unsigned CntW = clog2(N);

  state_e       state_q;
  logic [N-1:0] sh_a_q;
  logic [N-1:0] sh_b_q;
  logic [N-1:0] sh_s_q;
  logic         carry_q;
  logic         busy_q;
  logic         done_q;
  logic [N-1:0] s_q;
  logic         co_q;

  logic         sum_bit;
  logic         carry_d;
  logic [N-1:0] sh_s_d;
  logic         cnt_clr;
  logic         cnt_en;
  logic         cnt_last;

  // Single full-adder cell over the current LSBs and the held carry.
  always_comb begin
    sum_bit = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
    carry_d = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);
    sh_s_d  = {sum_bit, sh_s_q[N-1:1]};
    cnt_clr = (state_q == StIdle) && start;
    cnt_en  = (state_q == StRun);
  end

  sadd_bitcnt #(
    .N (N),
    .W (CntW)
  ) u_bitcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (cnt_last)
  );

  // Sequencer and datapath; s/co only update on the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_s_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            sh_a_q  <= a;
            sh_b_q  <= b;
            sh_s_q  <= '0;
            carry_q <= ci;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          sh_a_q  <= sh_a_q >> 1;
          sh_b_q  <= sh_b_q >> 1;
          sh_s_q  <= sh_s_d;
          carry_q <= carry_d;
          if (cnt_last) begin
            s_q     <= sh_s_d;
            co_q    <= carry_d;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (N=4).
module tb_serial_adder;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         co;

  int n_checks;
  int n_fail;
  int done_cnt;
  int ops_pushed;

  logic [N:0]   sb[$];
  logic [N:0]   mon_exp;
  logic [N-1:0] last_s;
  logic         last_co;

  serial_adder #(
    .N (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        mon_exp = sb.pop_front();
        check("sum", int'(s), int'(mon_exp[N-1:0]));
        check("carry", int'(co), int'(mon_exp[N]));
      end
    end
  end

  // One accepted operation with cycle-exact latency checks; optional start pulse while busy.
  task automatic run_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b, input logic op_ci,
                        input bit inject);
    logic [N:0] exp;
    int done_before;
    exp = model(op_a, op_b, op_ci);
    @(negedge clk);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    ci    = op_ci;
    sb.push_back(exp);
    ops_pushed++;
    done_before = done_cnt;
    @(negedge clk);
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    ci    = 1'($urandom);
    check("busy_accept", int'(busy), 1);
    check("s_hold", int'(s), int'(last_s));
    check("co_hold", int'(co), int'(last_co));
    for (int j = 1; j <= N + 1; j++) begin
      if (inject && j == 2) begin
        start = 1'b1;
        a     = N'(1);
        b     = N'(1);
        ci    = 1'b0;
      end
      if (inject && j == 3) start = 1'b0;
      @(negedge clk);
      check("done_lat", int'(done), int'(j == N));
      check("busy_lat", int'(busy), int'(j <= N));
    end
    check("one_done", done_cnt - done_before, 1);
    check("s_final", int'(s), int'(exp[N-1:0]));
    check("co_final", int'(co), int'(exp[N]));
    last_s  = exp[N-1:0];
    last_co = exp[N];
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    done_cnt   = 0;
    ops_pushed = 0;
    last_s     = '0;
    last_co    = 1'b0;
    start      = 1'b0;
    a          = '0;
    b          = '0;
    ci         = 1'b0;
    rst_n      = 1'b0;
    #23;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_s", int'(s), 0);
    check("rst_co", int'(co), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'b0011, 4'b0101, 1'b0, 1'b0);
    run_op(4'b1111, 4'b0001, 1'b0, 1'b0);
    run_op(4'b1111, 4'b1111, 1'b1, 1'b0);
    // Start pulse during RUN must be ignored; s/co still reflect these operands.
    run_op(4'b0010, 4'b0100, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("no_queued_op", int'(busy), 0);

    // Put a nonzero result in place, then abort an operation with reset.
    run_op(4'b1111, 4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 4'b1010;
    b     = 4'b0101;
    ci    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_s", int'(s), 0);
    check("abort_co", int'(co), 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", int'(done), 0);
    rst_n   = 1'b1;
    last_s  = '0;
    last_co = 1'b0;
    run_op(4'b0110, 4'b0011, 1'b0, 1'b0);

    // Start held high with operands changing every cycle: accept every N+2 edges.
    for (int c = 0; c < 4 * (N + 2); c++) begin
      start = 1'b1;
      a     = N'($urandom);
      b     = N'($urandom);
      ci    = 1'($urandom);
      if (c % (N + 2) == 0) begin
        sb.push_back(model(a, b, ci));
        ops_pushed++;
      end
      @(negedge clk);
      check("b2b_busy", int'(busy), int'((c % (N + 2)) != N + 1));
      check("b2b_done", int'(done), int'((c % (N + 2)) == N));
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_idle", int'(busy), 0);
    check("sb_empty", sb.size(), 0);
    check("done_total", done_cnt, ops_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
